// File: rtl/multireg.sv
// WIDTH-bit bus register: transparent-or-frozen input stage, edge-triggered load,
// synchronous clear/increment, and NOUT independently enabled tri-state bus ports.
module multireg #(
    parameter int unsigned       WIDTH    = 12,
    parameter int unsigned       NOUT     = 2,
    parameter logic [WIDTH-1:0]  RESETVAL = '0
) (
    input  logic                    SYSCLK,
    input  logic                    RESET,
    input  logic [WIDTH-1:0]        in,
    input  logic                    hold,
    input  logic                    latch,
    input  logic                    clr,
    input  logic                    inc,
    input  logic [NOUT-1:0]         oe,
    output logic [NOUT*WIDTH-1:0]   out,
    output logic [WIDTH-1:0]        value,
    output logic                    carry
);

    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_holdreg;
    logic             r_latch_q;
    logic             r_carry;

    logic [WIDTH-1:0] w_src;
    logic             w_rise;

    assign w_src  = hold ? r_holdreg : in;
    assign w_rise = latch & ~r_latch_q;

    // latch_q resets high so a latch held through reset cannot load on release
    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            r_data    <= RESETVAL;
            r_holdreg <= '0;
            r_latch_q <= 1'b1;
            r_carry   <= 1'b0;
        end else begin
            r_latch_q <= latch;
            r_carry   <= 1'b0;
            if (!hold)
                r_holdreg <= in;
            if (clr)
                r_data <= RESETVAL;
            else if (w_rise)
                r_data <= w_src;
            else if (inc) begin
                r_data  <= r_data + WIDTH'(1);
                r_carry <= &r_data;
            end
        end
    end

    assign value = r_data;
    assign carry = r_carry;

    for (genvar g = 0; g < NOUT; g++) begin : g_port
        assign out[g*WIDTH +: WIDTH] = oe[g] ? r_data : {WIDTH{1'bz}};
    end

endmodule

// File: tb/tb_multireg.sv
// Bench for multireg: directed vector table for the documented scenarios,
// combinational output-enable checks, then randomized traffic against a reference model.
module tb_multireg;

    localparam int unsigned WIDTH = 12;
    localparam int unsigned NOUT  = 3;
    localparam int unsigned RV    = 'o7777;
    localparam int unsigned MODV  = 4096;

    logic                  SYSCLK = 1'b0;
    logic                  RESET  = 1'b0;
    logic [WIDTH-1:0]      din    = '0;
    logic                  hold   = 1'b0;
    logic                  latch  = 1'b0;
    logic                  clr    = 1'b0;
    logic                  inc    = 1'b0;
    logic [NOUT-1:0]       oe     = '1;
    wire  [NOUT*WIDTH-1:0] w_out;
    logic [WIDTH-1:0]      value;
    logic                  carry;

    int checks = 0;
    int errors = 0;

    // reference model state (plain integers)
    int unsigned m_data  = 0;
    int unsigned m_hold  = 0;
    bit          m_lq    = 1'b1;
    bit          m_carry = 1'b0;

    multireg #(.WIDTH(WIDTH), .NOUT(NOUT), .RESETVAL(12'o7777)) dut (
        .SYSCLK (SYSCLK),
        .RESET  (RESET),
        .in     (din),
        .hold   (hold),
        .latch  (latch),
        .clr    (clr),
        .inc    (inc),
        .oe     (oe),
        .out    (w_out),
        .value  (value),
        .carry  (carry)
    );

    always #5 SYSCLK = ~SYSCLK;

    typedef struct {
        logic [4:0]       ctl;   // {RESET, hold, latch, clr, inc}
        logic [WIDTH-1:0] din;
        logic [WIDTH-1:0] exp_v;
        logic             exp_c;
    } vec_t;

    vec_t tbl[25];

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %o expected %o at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int unsigned src;
        bit          rise;
        src     = hold ? m_hold : int'(din);
        rise    = latch && !m_lq;
        m_carry = 1'b0;
        if (RESET) begin
            m_data = RV;
            m_hold = 0;
            m_lq   = 1'b1;
        end else begin
            if (clr)
                m_data = RV;
            else if (rise)
                m_data = src;
            else if (inc) begin
                m_carry = (m_data == MODV - 1);
                m_data  = (m_data + 1) % MODV;
            end
            if (!hold)
                m_hold = int'(din);
            m_lq = latch;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge SYSCLK);
        #1;
    endtask

    task automatic chk_ports(input string name, input logic [WIDTH-1:0] exp);
        for (int i = 0; i < int'(NOUT); i++) begin
            if (oe[i])
                chk($sformatf("%s_port%0d", name, i), w_out[i*WIDTH +: WIDTH], exp);
            else
                chk($sformatf("%s_port%0d_z", name, i), w_out[i*WIDTH +: WIDTH], {WIDTH{1'bz}});
        end
    endtask

    initial begin
        //                 {rst,hold,latch,clr,inc}  in        value      carry
        tbl[0]  = '{5'b10100, 12'o0000, 12'o7777, 1'b0};  // reset with latch high
        tbl[1]  = '{5'b00100, 12'o1234, 12'o7777, 1'b0};  // latch still high: no load
        tbl[2]  = '{5'b00000, 12'o1234, 12'o7777, 1'b0};
        tbl[3]  = '{5'b00100, 12'o1234, 12'o1234, 1'b0};  // transparent load
        tbl[4]  = '{5'b00100, 12'o4321, 12'o1234, 1'b0};  // held high: no reload
        tbl[5]  = '{5'b00000, 12'o0055, 12'o1234, 1'b0};  // input stage captures 0055
        tbl[6]  = '{5'b01100, 12'o7700, 12'o0055, 1'b0};  // frozen load
        tbl[7]  = '{5'b01000, 12'o7700, 12'o0055, 1'b0};
        tbl[8]  = '{5'b01100, 12'o1111, 12'o0055, 1'b0};  // still frozen value
        tbl[9]  = '{5'b00000, 12'o7776, 12'o0055, 1'b0};
        tbl[10] = '{5'b00100, 12'o7776, 12'o7776, 1'b0};
        tbl[11] = '{5'b00001, 12'o0000, 12'o7777, 1'b0};
        tbl[12] = '{5'b00001, 12'o0000, 12'o0000, 1'b1};  // wrap
        tbl[13] = '{5'b00001, 12'o0000, 12'o0001, 1'b0};
        tbl[14] = '{5'b00000, 12'o0000, 12'o0001, 1'b0};
        tbl[15] = '{5'b00111, 12'o2222, 12'o7777, 1'b0};  // clr beats rise and inc
        tbl[16] = '{5'b00000, 12'o0000, 12'o7777, 1'b0};
        tbl[17] = '{5'b00101, 12'o0100, 12'o0100, 1'b0};  // rise beats inc, no carry
        tbl[18] = '{5'b00000, 12'o0000, 12'o0100, 1'b0};
        tbl[19] = '{5'b10101, 12'o3333, 12'o7777, 1'b0};  // reset overrides rise+inc
        tbl[20] = '{5'b00100, 12'o3333, 12'o7777, 1'b0};  // no reload after reset
        tbl[21] = '{5'b00101, 12'o3333, 12'o0000, 1'b1};
        tbl[22] = '{5'b00000, 12'o3333, 12'o0000, 1'b0};
        tbl[23] = '{5'b00010, 12'o0000, 12'o7777, 1'b0};
        tbl[24] = '{5'b00000, 12'o0000, 12'o7777, 1'b0};

        oe = 3'b111;
        for (int k = 0; k < 25; k++) begin
            {RESET, hold, latch, clr, inc} = tbl[k].ctl;
            din = tbl[k].din;
            tick();
            chk($sformatf("vec%0d_value", k), value, tbl[k].exp_v);
            chk($sformatf("vec%0d_carry", k), WIDTH'(carry), WIDTH'(tbl[k].exp_c));
            chk_ports($sformatf("vec%0d", k), tbl[k].exp_v);
        end

        // oe is purely combinational: change it between edges
        oe = 3'b101;
        #1;
        chk_ports("oe101", 12'o7777);
        oe = 3'b000;
        #1;
        chk_ports("oe000", 12'o7777);
        oe = 3'b010;
        #1;
        chk_ports("oe010", 12'o7777);

        for (int n = 0; n < 600; n++) begin
            RESET = ($urandom_range(39) == 0);
            clr   = ($urandom_range(9) == 0);
            inc   = ($urandom_range(1) == 1);
            latch = ($urandom_range(1) == 1);
            hold  = ($urandom_range(1) == 1);
            din   = WIDTH'($urandom);
            oe    = NOUT'($urandom);
            tick();
            chk("rnd_value", value, WIDTH'(m_data));
            chk("rnd_carry", WIDTH'(carry), WIDTH'(m_carry));
            chk_ports("rnd", WIDTH'(m_data));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multireg.md
# multireg

Parametrised, fully synchronous successor to the CPU's 12-bit bus latches: a WIDTH-bit register with a transparent-or-frozen input stage, edge-detected load strobe, synchronous clear and increment (for PC/MA-style use), and NOUT independently enabled tri-state outputs onto separate internal buses. It sits between the major-register input mux and the CPU's shared buses. All state changes occur on the rising edge of SYSCLK.

## Interface
- WIDTH, 12, register and bus width in bits
- NOUT, 2, number of tri-state output ports
- RESETVAL, 0, value loaded into the register by RESET and by clr
- SYSCLK  in  1  system clock; all state updates on its rising edge
- RESET  in  1  synchronous, active-high reset
- in  in  WIDTH  data input
- hold  in  1  1 = input stage frozen; 0 = input stage transparent
- latch  in  1  load strobe, level input; only its rising edge loads
- clr  in  1  synchronous clear of the register to RESETVAL
- inc  in  1  synchronous increment of the register, level-sensitive, every cycle it is high
- oe  in  NOUT  per-port output enable
- out  out  NOUT*WIDTH  port i occupies bits [i*WIDTH +: WIDTH]
- value  out  WIDTH  register contents, always driven
- carry  out  1  one-cycle pulse when an increment wraps

## Operation
- State:
  - data: WIDTH-bit main register
  - holdreg: WIDTH-bit input stage
  - latch_q: previous-cycle sample of latch
  - carry: registered flag
- Input stage, each edge: if hold=0, holdreg <= in; if hold=1, holdreg keeps its value.
- Load source: src = hold ? holdreg : in. With hold=0 the block is transparent, so a load takes the current in.
- Strobe detect: rise = latch & ~latch_q; latch_q <= latch every edge.
- Register update priority, highest first:
  - RESET: data <= RESETVAL
  - clr: data <= RESETVAL
  - rise: data <= src
  - inc: data <= data + 1, modulo 2^WIDTH
  - otherwise: hold value
- carry <= 1 only when the inc branch is taken and data is all ones; else 0.
- A rise coinciding with inc loads src; the increment is dropped that cycle.
- clr coinciding with rise or inc: clr wins, and neither the load nor the increment occurs.
- Outputs, combinational from data:
  - out port i = oe[i] ? data : all-Z
  - value = data
- Ports are independent. Any combination of oe bits is legal and carries no contention check.

## Timing
- Reset values after a RESET edge:
  - data = RESETVAL
  - holdreg = 0
  - carry = 0
  - latch_q = 1
  - value = RESETVAL
  - out = RESETVAL on enabled ports, Z on the rest
- latch_q resets to 1 so a latch held high through reset does not load. latch must go low for at least one edge and then high before a load occurs.
- Load latency: latch sampled high (previous sample low) at edge N loads data at edge N; visible on value/out after edge N.
- hold timing: hold=1 sampled at edge N freezes the in value captured at edge N-1. A load at edge N+k (k≥1) with hold still 1 gets that value.
- A latch held high loads exactly once. One load requires a new low→high transition, with a minimum period of 2 cycles between loads.
- inc held high for k edges advances data by k mod 2^WIDTH.
- oe→out is combinational with zero cycle latency; out follows data the same cycle data changes.
- RESET mid-operation, e.g. during a held latch or an inc run, overrides everything at that edge. A latch still high afterwards does not reload.

## Test plan
- Reset/idle, WIDTH=12, RESETVAL=0o7777:
  - RESET one cycle with latch=1 held high throughout
  - Expect value=0o7777 and carry=0
  - Expect no load after reset release until latch goes 0 then 1.
- Transparent load: hold=0, in=0o1234, latch 0→1 → value=0o1234 after that edge. Keeping latch=1 and changing in to 0o4321 → value stays 0o1234.
- Frozen input:
  - in=0o0055, hold=0 for one edge, then hold=1 and in=0o7700
  - Pulse latch → value=0o0055
- Increment wrap:
  - Load 0o7776, then inc=1 for 3 edges → value 0o7777, 0o0000, 0o0001
  - carry=1 only during the cycle after the 0o7777→0o0000 edge.
- Priority, each from a known value:
  - clr+rise+inc same edge → RESETVAL
  - rise+inc → src, no carry even when data was 0o7777
- Outputs with NOUT=3:
  - oe=3'b101 → ports 0 and 2 equal value, port 1 all Z
  - oe=0 → all Z
  - Changing oe alters out without any SYSCLK edge.
